ex_mux4_rr_arbiter: RTL

//  Round-robin arbiter sharing one downstream valid/ready port among 4 requesters.

---
 rtl/ex_mux4_rr_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/ex_mux4_rr_arbiter.sv
// rtl/ex_mux4_rr_arbiter.sv - round-robin arbiter for 4 requesters sharing one valid/ready port
//
// Purpose:
//   Grants one of four requesters access to a single downstream valid/ready port.
//   It drives the select of an external shared 4:1 data mux and routes the
//   handshake. A grant is held for a whole burst, through the beat with last=1.
//   Simultaneous requests are resolved by rotating priority starting at ptr.
//   There is always one IDLE cycle between bursts.
//
// Configuration:
//   EX_ARB_PRIO0_EN - when defined, requester 0 wins any IDLE arbitration in
//                     which it is requesting. ptr still advances to sel+1.
//
// Ports:
//   ACLK       in   1  clock, rising edge
//   ARESETn    in   1  asynchronous active-low reset
//   req_valid  in   4  per-requester valid
//   req_last   in   4  per-requester last-beat flag, qualified by req_valid
//   req_ready  out  4  per-requester ready, one-hot or zero
//   out_valid  out  1  downstream valid
//   out_last   out  1  downstream last-beat flag
//   out_ready  in   1  downstream ready
//   sel        out  2  shared data mux select (0 = req0 .. 3 = req3)
//   busy       out  1  high while a grant is held

module ex_mux4_rr_arbiter (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic [3:0] req_valid,
    input  logic [3:0] req_last,
    output logic [3:0] req_ready,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic [1:0] sel,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;

    logic [1:0] winner;
    logic [1:0] idx;
    logic       found;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            sel_q   <= 2'b00;
            ptr_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        // Rotating-priority search: the first requester found scanning
        // ptr, ptr+1, ptr+2, ptr+3 (mod 4) wins.
        winner = ptr_q;
        idx    = ptr_q;
        found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
`ifdef EX_ARB_PRIO0_EN
        // Requester 0 overrides the rotation.
        // When it is not requesting, the search above already skips it.
        if (req_valid[0]) begin
            winner = 2'd0;
        end
`endif

        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        out_valid = 1'b0;
        out_last  = 1'b0;
        req_ready = 4'b0000;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    sel_d   = winner;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // The grant holds through bubbles.
                // Only a completed last beat releases it.
                out_valid = req_valid[sel_q];
                out_last  = req_last[sel_q] & req_valid[sel_q];
                req_ready = (4'b0001 << sel_q) & {4{out_ready}};
                if (out_valid && out_ready && out_last) begin
                    state_d = IDLE;
                    ptr_d   = sel_q + 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sel  = sel_q;
    assign busy = (state_q == BUSY);

endmodule
